// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, FSM states,
// mask width and the alignment rule reused by lsu_align.
package lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    localparam int          MEM_MASK_W = 8;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request, memory bus and write-back response signals of lsu_ctrl.
// A transfer on any valid/ready pair happens on a rising clk edge where both are
// high; the valid side holds its payload stable until that edge.
interface lsu_ctrl_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_load_i;
    logic                  req_store_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_W-1:0]     req_addr_i;
    logic [DATA_W-1:0]     req_wdata_i;

    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_req_wen_o;
    logic [ADDR_W-1:0]     mem_req_addr_o;
    logic [DATA_W-1:0]     mem_req_wdata_o;
    logic [MEM_MASK_W-1:0] mem_req_wmask_o;
    logic                  mem_rsp_valid_i;
    logic [DATA_W-1:0]     mem_rsp_rdata_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;

    modport slave (
        input  req_valid_i, req_load_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output mem_req_valid_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_load_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  mem_req_valid_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-lane data/mask, legality and alignment
// checks for an incoming request, and sign/zero extension of a returned word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                  op_load,
    input  logic                  op_store,
    input  logic [2:0]            req_funct3,
    input  logic [1:0]            req_addr_lo,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           lane_wdata,
    output logic [MEM_MASK_W-1:0] lane_mask,
    output logic                  illegal,
    output logic                  misaligned,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_addr_lo,
    input  logic [31:0]           ld_rdata,
    output logic [31:0]           ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (op_load && op_store) begin
            illegal = 1'b1;
        end else if (op_load) begin
            illegal = !(req_funct3 inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU});
        end else if (op_store) begin
            illegal = !(req_funct3 inside {LSU_SB, LSU_SH, LSU_SW});
        end
        // A no-op carries a don't-care funct3, so it must never flag misalignment.
        if (op_load || op_store) begin
            misaligned = lsu_misaligned(req_funct3[1:0], req_addr_lo);
        end
    end

    always_comb begin
        lane_wdata = req_wdata;
        lane_mask  = 8'h0F;
        case (req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_mask  = {4'b0000, 4'b0001 << req_addr_lo};
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_mask  = req_addr_lo[1] ? 8'h0C : 8'h03;
            end
            default: begin
                lane_wdata = req_wdata;
                lane_mask  = 8'h0F;
            end
        endcase
    end

    always_comb begin
        ld_data = ZERO_WORD;
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            LSU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LSU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            LSU_LW:  ld_data = ld_rdata;
            LSU_LBU: ld_data = {24'h000000, ld_byte};
            LSU_LHU: ld_data = {16'h0000, ld_half};
            default: ld_data = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one operation at a time from Execute, runs it
// over a valid/ready memory bus and returns extended load data to write-back.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output lsu_state_e state_o
);

    lsu_state_e            state;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  is_load_q;

    logic [DATA_W-1:0]     lane_wdata;
    logic [MEM_MASK_W-1:0] lane_mask;
    logic [DATA_W-1:0]     ld_data;
    logic                  illegal;
    logic                  misaligned;
    logic                  noop;

    assign state_o = state;
    assign noop    = !bus.req_load_i && !bus.req_store_i;

    lsu_align u_align (
        .op_load     (bus.req_load_i),
        .op_store    (bus.req_store_i),
        .req_funct3  (bus.req_funct3_i),
        .req_addr_lo (bus.req_addr_i[1:0]),
        .req_wdata   (bus.req_wdata_i),
        .lane_wdata  (lane_wdata),
        .lane_mask   (lane_mask),
        .illegal     (illegal),
        .misaligned  (misaligned),
        .ld_funct3   (funct3_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_rdata    (bus.mem_rsp_rdata_i),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state               <= LSU_IDLE;
            funct3_q            <= 3'b000;
            addr_lo_q           <= 2'b00;
            is_load_q           <= 1'b0;
            bus.req_ready_o     <= 1'b1;
            bus.mem_req_valid_o <= 1'b0;
            bus.mem_req_wen_o   <= 1'b0;
            bus.mem_req_addr_o  <= '0;
            bus.mem_req_wdata_o <= ZERO_WORD;
            bus.mem_req_wmask_o <= '0;
            bus.rsp_valid_o     <= 1'b0;
            bus.rsp_rdata_o     <= ZERO_WORD;
            bus.rsp_err_o       <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (bus.req_valid_i && bus.req_ready_o) begin
                        funct3_q        <= bus.req_funct3_i;
                        addr_lo_q       <= bus.req_addr_i[1:0];
                        is_load_q       <= bus.req_load_i;
                        bus.req_ready_o <= 1'b0;
                        if (illegal || misaligned) begin
                            state           <= LSU_RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_rdata_o <= ZERO_WORD;
                            bus.rsp_err_o   <= 1'b1;
                        end else if (noop) begin
                            state           <= LSU_RESP;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_rdata_o <= ZERO_WORD;
                            bus.rsp_err_o   <= 1'b0;
                        end else begin
                            state               <= LSU_REQ;
                            bus.mem_req_valid_o <= 1'b1;
                            bus.mem_req_wen_o   <= bus.req_store_i;
                            bus.mem_req_addr_o  <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                            // Loads put no data or enables on the write lanes.
                            bus.mem_req_wdata_o <= bus.req_store_i ? lane_wdata : ZERO_WORD;
                            bus.mem_req_wmask_o <= bus.req_store_i ? lane_mask : '0;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.mem_req_ready_i) begin
                        state               <= LSU_WAIT;
                        bus.mem_req_valid_o <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (bus.mem_rsp_valid_i) begin
                        state           <= LSU_RESP;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_err_o   <= 1'b0;
                        bus.rsp_rdata_o <= is_load_q ? ld_data : ZERO_WORD;
                    end
                end
                LSU_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state           <= LSU_IDLE;
                        bus.rsp_valid_o <= 1'b0;
                        bus.rsp_rdata_o <= ZERO_WORD;
                        bus.rsp_err_o   <= 1'b0;
                        bus.req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a 16-word memory model answers the bus with
// random stalls, and a reference model predicts every request and response.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    lsu_state_e state_o;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [16];
    logic [32:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the request should do, from the ISA rules.
    task automatic model_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic access, output logic [31:0] eaddr,
                             output logic [31:0] ewdata, output logic [7:0] emask,
                             output logic [32:0] eresp);
        int          size;
        int          ofs;
        logic        legal;
        logic [31:0] v;
        size   = 1 << f3[1:0];
        ofs    = int'(addr % 4);
        access = 1'b0;
        eaddr  = addr & 32'hFFFF_FFFC;
        ewdata = 32'h0;
        emask  = 8'h0;
        eresp  = 33'h0;
        if (ld && st)  legal = 1'b0;
        else if (ld)   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else if (st)   legal = (f3 <= 3'd2);
        else           legal = 1'b1;
        if (!ld && !st) begin
            eresp = 33'h0;
        end else if (!legal || (addr % size) != 0) begin
            eresp = {1'b1, 32'h0};
        end else begin
            access = 1'b1;
            if (st) begin
                if (size == 1)      ewdata = {24'h0, wdata[7:0]} * 32'h0101_0101;
                else if (size == 2) ewdata = {16'h0, wdata[15:0]} * 32'h0001_0001;
                else                ewdata = wdata;
                emask = 8'(((1 << size) - 1) << ofs);
            end else begin
                v = mem[addr[5:2]] >> (8 * ofs);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                end
                eresp = {1'b0, v};
            end
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input int lat, input int hold);
        logic        access;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [7:0]  emask;
        logic [32:0] eresp;
        model_req(ld, st, f3, addr, wdata, access, eaddr, ewdata, emask, eresp);
        exp_q.push_back(eresp);
        check("req_ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i  = 1'b1;
        bus.req_load_i   = ld;
        bus.req_store_i  = st;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(negedge clk);
        bus.req_valid_i  = 1'b0;
        bus.req_wdata_i  = $urandom;
        if (access) begin
            for (int i = 0; i <= stall; i++) begin
                check("mem_req_valid", bus.mem_req_valid_o, 1);
                check("mem_req_addr", bus.mem_req_addr_o, eaddr);
                check("mem_req_wen", bus.mem_req_wen_o, st);
                if (st) begin
                    check("mem_req_wdata", bus.mem_req_wdata_o, ewdata);
                    check("mem_req_wmask", bus.mem_req_wmask_o, emask);
                end
                check("req_ready_busy", bus.req_ready_o, 0);
                bus.mem_req_ready_i = (i == stall);
                @(negedge clk);
            end
            bus.mem_req_ready_i = 1'b0;
            check("mem_req_dropped", bus.mem_req_valid_o, 0);
            for (int i = 0; i < lat; i++) begin
                check("rsp_early", bus.rsp_valid_o, 0);
                @(negedge clk);
            end
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_rdata_i = st ? $urandom : mem[addr[5:2]];
            @(negedge clk);
            bus.mem_rsp_valid_i = 1'b0;
            bus.mem_rsp_rdata_i = $urandom;
            if (st) begin
                for (int b = 0; b < 4; b++)
                    if (emask[b]) mem[addr[5:2]][8*b +: 8] = ewdata[8*b +: 8];
            end
        end else begin
            check("no_mem_req", bus.mem_req_valid_o, 0);
        end
        eresp = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", bus.rsp_valid_o, 1);
            check("rsp_rdata", bus.rsp_rdata_o, eresp[31:0]);
            check("rsp_err", bus.rsp_err_o, eresp[32]);
            check("req_ready_resp", bus.req_ready_o, 0);
            check("no_mem_req_resp", bus.mem_req_valid_o, 0);
            bus.rsp_ready_i = (i == hold);
            // A competing request while the result is pending must be ignored.
            bus.req_valid_i  = (i < hold);
            bus.req_load_i   = 1'b1;
            bus.req_store_i  = 1'b0;
            bus.req_funct3_i = LSU_LW;
            bus.req_addr_i   = 32'h8000_0000;
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b0;
        check("rsp_done", bus.rsp_valid_o, 0);
        check("req_ready_back", bus.req_ready_o, 1);
        check("no_stray_req", bus.mem_req_valid_o, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, bus.req_ready_o, 1);
        check({tag, "_mem_valid"}, bus.mem_req_valid_o, 0);
        check({tag, "_mem_wen"}, bus.mem_req_wen_o, 0);
        check({tag, "_mem_addr"}, bus.mem_req_addr_o, 0);
        check({tag, "_mem_wdata"}, bus.mem_req_wdata_o, 0);
        check({tag, "_mem_wmask"}, bus.mem_req_wmask_o, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid_o, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 0);
        check({tag, "_rsp_err"}, bus.rsp_err_o, 0);
        check({tag, "_state"}, state_o, LSU_IDLE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        int          k;
        bus.req_valid_i     = 1'b0;
        bus.req_load_i      = 1'b0;
        bus.req_store_i     = 1'b0;
        bus.req_funct3_i    = 3'b000;
        bus.req_addr_i      = 32'h0;
        bus.req_wdata_i     = 32'h0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_rdata_i = 32'h0;
        bus.rsp_ready_i     = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed stores.
        do_op(1'b0, 1'b1, LSU_SW, 32'h8000_0004, 32'hDEAD_BEEF, 2, 0, 0);
        check("sw_mem", mem[1], 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, LSU_SB, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0);
        do_op(1'b0, 1'b1, LSU_SH, 32'h8000_0002, 32'h0000_1234, 0, 1, 0);

        // Directed loads on a known word.
        mem[0] = 32'h80F0_7F81;
        do_op(1'b1, 1'b0, LSU_LB,  32'h8000_0000, 32'h0, 0, 0, 0);
        do_op(1'b1, 1'b0, LSU_LBU, 32'h8000_0000, 32'h0, 0, 0, 0);
        do_op(1'b1, 1'b0, LSU_LB,  32'h8000_0001, 32'h0, 1, 0, 0);
        do_op(1'b1, 1'b0, LSU_LH,  32'h8000_0002, 32'h0, 0, 2, 0);
        do_op(1'b1, 1'b0, LSU_LHU, 32'h8000_0002, 32'h0, 0, 0, 1);

        // Errors and a no-op.
        do_op(1'b1, 1'b0, LSU_LW, 32'h8000_0002, 32'h0, 0, 0, 0);
        do_op(1'b1, 1'b0, LSU_LH, 32'h8000_0001, 32'h0, 0, 0, 0);
        do_op(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 0, 0, 0);
        do_op(1'b1, 1'b1, LSU_LW, 32'h8000_0000, 32'h0, 0, 0, 0);
        do_op(1'b0, 1'b0, LSU_LW, 32'h8000_0001, 32'h0, 0, 0, 0);

        // Back-to-back loads with write-back stalled.
        do_op(1'b1, 1'b0, LSU_LW, 32'h8000_0008, 32'h0, 0, 0, 4);
        do_op(1'b1, 1'b0, LSU_LW, 32'h8000_000C, 32'h0, 0, 0, 4);

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 9);
            ld = (k < 5) || (k == 8);
            st = (k >= 5 && k < 8) || (k == 8);
            if ($urandom_range(0, 9) < 8) begin
                if (st && !ld) f3 = 3'($urandom_range(0, 2));
                else           f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2))
                                                                : 3'($urandom_range(4, 5));
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            do_op(ld, st, f3, 32'h8000_0000 + 32'($urandom_range(0, 63)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while waiting for a memory response.
        bus.req_valid_i  = 1'b1;
        bus.req_load_i   = 1'b1;
        bus.req_store_i  = 1'b0;
        bus.req_funct3_i = LSU_LW;
        bus.req_addr_i   = 32'h8000_0010;
        @(negedge clk);
        bus.req_valid_i     = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_req_ready_i = 1'b0;
        check("wait_state", state_o, LSU_WAIT);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b0;
        check("stray_rsp_valid", bus.rsp_valid_o, 0);
        check("stray_req_ready", bus.req_ready_o, 1);
        @(negedge clk);
        check("stray_rsp_valid2", bus.rsp_valid_o, 0);
        do_op(1'b1, 1'b0, LSU_LW, 32'h8000_0000, 32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage between Execute and the data-memory port. Accepts one load or store per request, checks alignment, builds the byte-lane store data and mask, and drives a valid/ready memory request/response bus. Returns sign- or zero-extended load data to write-back. Data filtering and read-data expansion are folded into one multi-cycle FSM, which lets the NPC move from the combinational DPI memory to a latency-tolerant bus.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be 32.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid_i` input 1: Execute has a memory operation.
- `req_ready_o` output 1: LSU can accept a request; high only in IDLE.
- `req_load_i` input 1: the operation is a load.
- `req_store_i` input 1: the operation is a store. Setting both load and store is illegal.
- `req_funct3_i` input 3: RV32I size/sign code.
- `req_addr_i` input ADDR_W: byte address.
- `req_wdata_i` input DATA_W: store source (rs2), unshifted.
- `mem_req_valid_o` output 1: memory request valid.
- `mem_req_ready_i` input 1: memory accepts the request.
- `mem_req_wen_o` output 1: the request is a write.
- `mem_req_addr_o` output ADDR_W: word-aligned address (low 2 bits zero).
- `mem_req_wdata_o` output DATA_W: lane-shifted store data.
- `mem_req_wmask_o` output 8: byte mask; bits [7:4] always 0.
- `mem_rsp_valid_i` input 1: memory response valid. Sent for reads and writes.
- `mem_rsp_rdata_i` input DATA_W: read word; ignored for writes.
- `rsp_valid_o` output 1: result for write-back.
- `rsp_ready_i` input 1: write-back consumes the result.
- `rsp_rdata_o` output DATA_W: extended load data; 0 for stores and errors.
- `rsp_err_o` output 1: misaligned access or illegal funct3.

## Operation
- Load codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Store codes: 000 SB, 001 SH, 010 SW.
- Any other code, or load and store both set, is illegal. Neither set is a no-op: it returns `rsp_valid_o` with rdata 0 and err 0, and no bus access.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0. This raises an error response with no memory request.
- Store lanes:
  - SB: data = {4{wdata[7:0]}}, mask = 1<<addr[1:0].
  - SH: data = {2{wdata[15:0]}}, mask = 0011 or 1100 by addr[1].
  - SW: mask = 1111.
- Load extraction uses the captured addr[1:0] to select the byte or halfword. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE→REQ: on `req_valid_i & req_ready_o`, legal and aligned. Opcode, funct3, addr and wdata are captured.
  - IDLE→RESP: on an accepted request that is illegal, misaligned, or a no-op.
  - REQ→WAIT: when `mem_req_ready_i` is high. Valid stays asserted with stable fields until then.
  - WAIT→RESP: when `mem_rsp_valid_i` is high. Read data is extended and registered.
  - RESP→IDLE: when `rsp_ready_i` is high. Outputs hold stable until then.
- Responses arriving outside WAIT are ignored.

## Timing
- Reset values: state IDLE, all `*_valid_o` 0, `req_ready_o` 1, all data/addr/mask outputs 0, `rsp_err_o` 0.
- Reset mid-transaction aborts the FSM to IDLE immediately. An outstanding memory request is dropped, and memory must also be reset.
- Zero-wait memory (ready and rsp_valid tied high): accept at cycle N, mem request at N+1, response captured at N+2, `rsp_valid_o` at N+2 → N+3 visible. Minimum load-to-use is 3 cycles after accept.
- Error or no-op: `rsp_valid_o` appears in cycle N+1.
- Throughput: one operation in flight. `req_ready_o` is low from accept until the RESP handshake completes; `req_ready_o` rises in the cycle after the RESP handshake.
- All outputs are registered. There is no combinational path from `mem_*_i` or `rsp_ready_i` to any output.

## Structure
- Shared package `lsu_pkg`:
  - funct3 localparams (`LSU_LB` … `LSU_SW`)
  - FSM state enum
  - `MEM_MASK_W` = 8
- Constants already in `defines.v` (`RST_ENABLE`, `ZERO_WORD`) are reused.
- One sub-module, `lsu_align`: a combinational store-lane builder, load extender and misalignment check. It is shared with any future ICache/MMIO path.

## Test plan
- SW addr 0x80000004 data 0xDEADBEEF, memory ready after 2 stall cycles → mem_req held 3 cycles with addr 0x80000004, wdata 0xDEADBEEF, mask 0x0F. After the response, `rsp_valid_o` with rdata 0 and err 0.
- SB addr 0x80000003 data 0x000000A5 → wdata 0xA5A5A5A5, mask 0x08. SH addr 0x80000002 data 0x1234 → wdata 0x12341234, mask 0x0C.
- Memory word 0x80F0_7F81 at 0x80000000:
  - LB addr+0 → 0xFFFFFF81
  - LBU addr+0 → 0x00000081
  - LB addr+1 → 0x0000007F
  - LH addr+2 → 0xFFFF80F0
  - LHU addr+2 → 0x000080F0
- LW addr 0x80000002 and LH addr 0x80000001 → no `mem_req_valid_o`, err 1 in cycle N+1. funct3 011 load → err 1.
- Back-to-back loads, `rsp_ready_i` low for 4 cycles → `rsp_rdata_o` is stable, `req_ready_o` stays 0, and the second request is not accepted until the handshake completes.
- Assert `rst` while in WAIT → all outputs take their reset values without waiting for a clock edge. A stray `mem_rsp_valid_i` afterwards produces no `rsp_valid_o`.
